// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 opcodes, op enum, field positions, immediate ranges
package legv8_pkg;
   typedef enum logic [2:0] {
      OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ, OP_B
   } op_t;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [5:0]  OPC_B    = 6'b000101;
   localparam int OPC_LSB    = 21;
   localparam int CBOPC_LSB  = 24;
   localparam int BOPC_LSB   = 26;
   localparam int RM_LSB     = 16;
   localparam int SHAMT_LSB  = 10;
   localparam int DIMM_LSB   = 12;
   localparam int CBIMM_LSB  = 5;
   localparam int RN_LSB     = 5;
   localparam int RD_LSB     = 0;
   localparam int D_IMM_MIN  = -256;
   localparam int D_IMM_MAX  = 255;
   localparam int CB_IMM_MIN = -(1 << 18);
   localparam int CB_IMM_MAX = (1 << 18) - 1;
   typedef struct packed {
      logic [31:0] word;
      logic        err;
   } entry_t;
endpackage

// File: rtl/legv8_encode.sv
// legv8_encode: combinational {op, regs, imm} -> {32-bit word, range error}
// Ports: op/rd/rn/rm/shamt/imm in; word = packed instruction, err = imm overflowed its field.
module legv8_encode
   import legv8_pkg::*;
(
   input  op_t         op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rn,
   input  logic [4:0]  rm,
   input  logic [5:0]  shamt,
   input  logic [25:0] imm,
   output logic [31:0] word,
   output logic        err
);
   logic [10:0] r_opc;
   logic [31:0] r_word, d_word, cb_word, b_word;
   logic        d_err, cb_err;
   always_comb begin
      r_opc   = op == OP_ADD ? OPC_ADD : op == OP_SUB ? OPC_SUB : op == OP_AND ? OPC_AND : OPC_ORR;
      r_word  = 32'(r_opc) << OPC_LSB | 32'(rm) << RM_LSB | 32'(shamt) << SHAMT_LSB
              | 32'(rn) << RN_LSB | 32'(rd) << RD_LSB;
      d_word  = 32'(op == OP_LDUR ? OPC_LDUR : OPC_STUR) << OPC_LSB | 32'(imm[8:0]) << DIMM_LSB
              | 32'(rn) << RN_LSB | 32'(rd) << RD_LSB;
      cb_word = 32'(OPC_CBZ) << CBOPC_LSB | 32'(imm[18:0]) << CBIMM_LSB | 32'(rd) << RD_LSB;
      b_word  = 32'(OPC_B) << BOPC_LSB | 32'(imm);
      d_err   = $signed(imm) < D_IMM_MIN || $signed(imm) > D_IMM_MAX;
      cb_err  = $signed(imm) < CB_IMM_MIN || $signed(imm) > CB_IMM_MAX;
      word    = op inside {OP_LDUR, OP_STUR} ? d_word : op == OP_CBZ ? cb_word : op == OP_B ? b_word : r_word;
      err     = op inside {OP_LDUR, OP_STUR} ? d_err : op == OP_CBZ ? cb_err : 1'b0;
   end
endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: buffered LEGv8 encoder with 2-entry output FIFO and word-address tagging
// Ports: CLK/Reset; In* = request handshake and fields; Out* = encoded head word, its address and
// range-error flag; ErrSticky latches any emitted range error until Reset.
module legv8_instr_encoder
   import legv8_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int BASE   = 0
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [2:0]        InOp,
   input  logic [4:0]        InRd,
   input  logic [4:0]        InRn,
   input  logic [4:0]        InRm,
   input  logic [5:0]        InShamt,
   input  logic [25:0]       InImm,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [31:0]       OutInstr,
   output logic [ADDR_W-1:0] OutAddr,
   output logic              OutRangeErr,
   output logic              ErrSticky
);
   entry_t            enc, e0, e1;
   logic [1:0]        cnt, cnt_p, cnt_n;
   logic [ADDR_W-1:0] addr;
   logic              rdy, sticky, push, pop;
   legv8_encode u_enc (
      .op(op_t'(InOp)), .rd(InRd), .rn(InRn), .rm(InRm), .shamt(InShamt), .imm(InImm),
      .word(enc.word), .err(enc.err)
   );
   // cnt_p is occupancy after the pop, which decides where a same-cycle push lands
   assign push  = InValid && rdy;
   assign pop   = cnt != 2'd0 && OutReady;
   assign cnt_p = cnt - 2'(pop);
   assign cnt_n = cnt_p + 2'(push);
   always_ff @(posedge CLK) begin
      if (Reset) begin
         cnt    <= '0;
         e0     <= '0;
         e1     <= '0;
         addr   <= ADDR_W'(BASE);
         rdy    <= 1'b0;
         sticky <= 1'b0;
      end else begin
         cnt    <= cnt_n;
         e0     <= push && cnt_p == 2'd0 ? enc : pop ? e1 : e0;
         e1     <= push && cnt_p == 2'd1 ? enc : e1;
         addr   <= addr + ADDR_W'(pop);
         rdy    <= cnt_n < 2'd2;
         sticky <= sticky | (pop & e0.err);
      end
   end
   assign InReady     = rdy;
   assign OutValid    = cnt != 2'd0;
   assign OutInstr    = e0.word;
   assign OutRangeErr = e0.err;
   assign OutAddr     = addr;
   assign ErrSticky   = sticky;
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder: directed and random scoreboard bench for legv8_instr_encoder
module tb_legv8_instr_encoder;
   localparam int AW = 2;
   typedef struct packed {
      logic [31:0] w;
      logic        e;
   } ent_t;
   logic          CLK = 1'b0, Reset = 1'b1, InValid = 1'b0, OutReady = 1'b0;
   logic [2:0]    InOp = '0;
   logic [4:0]    InRd = '0, InRn = '0, InRm = '0;
   logic [5:0]    InShamt = '0;
   logic [25:0]   InImm = '0;
   logic          InReady, OutValid, OutRangeErr, ErrSticky;
   logic [31:0]   OutInstr;
   logic [AW-1:0] OutAddr;
   ent_t          sb[$];
   logic [AW-1:0] exp_addr = '0;
   logic          exp_sticky = 1'b0;
   int            total = 0, bad = 0;

   legv8_instr_encoder #(.ADDR_W(AW), .BASE(0)) dut (
      .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InOp(InOp),
      .InRd(InRd), .InRn(InRn), .InRm(InRm), .InShamt(InShamt), .InImm(InImm),
      .OutValid(OutValid), .OutReady(OutReady), .OutInstr(OutInstr), .OutAddr(OutAddr),
      .OutRangeErr(OutRangeErr), .ErrSticky(ErrSticky)
   );

   always #5 CLK = ~CLK;

   function automatic ent_t enc(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic [5:0] sh, input logic [25:0] imm);
      ent_t r;
      int   v;
      v = int'($signed(imm));
      r.e = 1'b0;
      case (op)
         3'd0: begin r.w = {11'b11111000010, imm[8:0], 2'b00, rn, rd}; r.e = v < -256 || v > 255; end
         3'd1: begin r.w = {11'b11111000000, imm[8:0], 2'b00, rn, rd}; r.e = v < -256 || v > 255; end
         3'd2: r.w = {11'b10001011000, rm, sh, rn, rd};
         3'd3: r.w = {11'b11001011000, rm, sh, rn, rd};
         3'd4: r.w = {11'b10001010000, rm, sh, rn, rd};
         3'd5: r.w = {11'b10101010000, rm, sh, rn, rd};
         3'd6: begin r.w = {8'b10110100, imm[18:0], rd}; r.e = v < -262144 || v > 262143; end
         default: r.w = {6'b000101, imm};
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [5:0] sh, input int imm);
      InValid = 1'b1; InOp = op; InRd = rd; InRn = rn; InRm = rm; InShamt = sh; InImm = 26'(imm);
   endtask

   // One clock: score the handshakes seen before the edge, then check state after it.
   task automatic step();
      logic push, pop;
      ent_t hd;
      hd   = '0;
      push = InValid && InReady;
      pop  = OutValid && OutReady;
      if (!Reset && pop) begin
         if (sb.size() == 0) chk("unexpected_valid", 32'(OutValid), 32'd0);
         else begin
            hd = sb.pop_front();
            chk("instr", OutInstr, hd.w);
            chk("range_err", 32'(OutRangeErr), 32'(hd.e));
            chk("addr", 32'(OutAddr), 32'(exp_addr));
         end
      end
      if (!Reset && push) sb.push_back(enc(InOp, InRd, InRn, InRm, InShamt, InImm));
      @(posedge CLK);
      #1;
      if (Reset) begin
         sb.delete();
         exp_addr   = '0;
         exp_sticky = 1'b0;
         chk("rst_inready", 32'(InReady), 32'd0);
         chk("rst_outvalid", 32'(OutValid), 32'd0);
         chk("rst_instr", OutInstr, 32'd0);
         chk("rst_rangeerr", 32'(OutRangeErr), 32'd0);
         chk("rst_addr", 32'(OutAddr), 32'd0);
         chk("rst_sticky", 32'(ErrSticky), 32'd0);
      end else begin
         if (pop) begin
            exp_addr++;
            if (hd.e) exp_sticky = 1'b1;
         end
         chk("valid", 32'(OutValid), 32'(sb.size() != 0));
         chk("inready", 32'(InReady), 32'(sb.size() < 2));
         chk("sticky", 32'(ErrSticky), 32'(exp_sticky));
      end
   endtask

   task automatic drain();
      InValid  = 1'b0;
      OutReady = 1'b1;
      for (int i = 0; i < 8 && sb.size() != 0; i++) step();
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [31:0]   saved;
      logic [AW-1:0] saved_a;
      logic          acc;
      logic [AW-1:0] wa[5];
      wa = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      step(); step();
      Reset = 1'b0;
      step();
      chk("inready_after_reset", 32'(InReady), 32'd1);
      // ADD X3,X1,X2 held in buffer, then popped
      req(3'd2, 5'd3, 5'd1, 5'd2, 6'd0, 0);
      step();
      InValid = 1'b0;
      chk("add_word", OutInstr, 32'h8B020023);
      chk("add_addr", 32'(OutAddr), 32'd0);
      chk("add_err", 32'(OutRangeErr), 32'd0);
      OutReady = 1'b1;
      step();
      // back-to-back LDUR, CBZ, B after a fresh reset
      Reset = 1'b1; step(); Reset = 1'b0; step();
      req(3'd0, 5'd9, 5'd22, 5'd0, 6'd0, 64); step();
      chk("ldur_word", OutInstr, 32'hF84402C9);
      chk("ldur_addr", 32'(OutAddr), 32'd0);
      req(3'd6, 5'd5, 5'd0, 5'd0, 6'd0, -2); step();
      chk("cbz_word", OutInstr, 32'hB4FFFFC5);
      chk("cbz_addr", 32'(OutAddr), 32'd1);
      req(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 3); step();
      chk("b_word", OutInstr, 32'h14000003);
      chk("b_addr", 32'(OutAddr), 32'd2);
      // STUR out of range: sticky error after its pop
      req(3'd1, 5'd0, 5'd0, 5'd0, 6'd0, 300); step();
      chk("stur_word", OutInstr, 32'hF812C000);
      chk("stur_err", 32'(OutRangeErr), 32'd1);
      chk("stur_sticky_before_pop", 32'(ErrSticky), 32'd0);
      InValid = 1'b0; step();
      chk("stur_sticky", 32'(ErrSticky), 32'd1);
      step(); step();
      // immediate range boundaries
      req(3'd0, 5'd1, 5'd2, 5'd0, 6'd0, 255); step();
      req(3'd0, 5'd1, 5'd2, 5'd0, 6'd0, -256); step();
      req(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 256); step();
      req(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, -257); step();
      req(3'd6, 5'd7, 5'd0, 5'd0, 6'd0, 262143); step();
      req(3'd6, 5'd7, 5'd0, 5'd0, 6'd0, -262144); step();
      req(3'd6, 5'd7, 5'd0, 5'd0, 6'd0, 262144); step();
      req(3'd6, 5'd7, 5'd0, 5'd0, 6'd0, -262145); step();
      req(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, -33554432); step();
      drain();
      // backpressure: third request waits until a slot frees
      OutReady = 1'b0;
      req(3'd3, 5'd4, 5'd5, 5'd6, 6'd7, 0); step();
      req(3'd4, 5'd8, 5'd9, 5'd10, 6'd11, 0); step();
      chk("full_inready", 32'(InReady), 32'd0);
      req(3'd5, 5'd12, 5'd13, 5'd14, 6'd15, 0);
      saved = OutInstr; saved_a = OutAddr;
      step(); step();
      chk("hold_instr", OutInstr, saved);
      chk("hold_addr", 32'(OutAddr), 32'(saved_a));
      OutReady = 1'b1;
      for (int i = 0; i < 10 && InValid; i++) begin
         acc = InReady;
         step();
         if (acc) InValid = 1'b0;
      end
      chk("third_accept_timeout", 32'(InValid), 32'd0);
      drain();
      // random traffic
      for (int i = 0; i < 40; i++) begin
         OutReady = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0)
            req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                $urandom_range(0, 1) ? int'($urandom_range(0, 600)) - 300
                                     : int'($urandom_range(0, 600000)) - 300000);
         else InValid = 1'b0;
         step();
      end
      drain();
      // address wrap with a 2-bit counter
      Reset = 1'b1; step(); Reset = 1'b0; step();
      for (int i = 0; i < 5; i++) begin
         req(3'd2, 5'(i), 5'd1, 5'd1, 6'd0, 0);
         step();
         chk("wrap_addr", 32'(OutAddr), 32'(wa[i]));
      end
      InValid = 1'b0; step();
      // reset with two words buffered and the sticky flag set
      req(3'd1, 5'd0, 5'd0, 5'd0, 6'd0, 300); step();
      InValid = 1'b0; step();
      chk("sticky_set", 32'(ErrSticky), 32'd1);
      OutReady = 1'b0;
      req(3'd2, 5'd1, 5'd1, 5'd1, 6'd0, 0); step();
      req(3'd0, 5'd1, 5'd1, 5'd0, 6'd0, 8); step();
      InValid = 1'b0;
      chk("two_buffered", 32'(InReady), 32'd0);
      Reset = 1'b1; step();
      Reset = 1'b0; step();
      chk("post_reset_inready", 32'(InReady), 32'd1);
      OutReady = 1'b1;
      req(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 3); step();
      chk("post_reset_addr", 32'(OutAddr), 32'd0);
      chk("post_reset_word", OutInstr, 32'h14000003);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
